// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for alu_share_arb: ALU op codes, NZCV bit positions, reset values.
package alu_share_arb_pkg;

    localparam int ALU_W = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] FLAGS_RESET = 4'b0000;

    // One operation as presented to the shared ALU.
    typedef struct packed {
        logic [2:0]       op;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
    } alu_req_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// Requester/response bundle for alu_share_arb. The set_flags/flagsX_q signals
// exist only when ALU_ARB_FLAGREG_EN is defined.
interface alu_share_arb_if #(parameter int DATA_W = 32);
    logic              req0;
    logic [2:0]        op0;
    logic [DATA_W-1:0] a0;
    logic [DATA_W-1:0] b0;
    logic              gnt0;
    logic              req1;
    logic [2:0]        op1;
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] b1;
    logic              gnt1;
    logic              rsp_valid0;
    logic              rsp_valid1;
    logic [DATA_W-1:0] result;
    logic [3:0]        flags;
    logic              busy;
`ifdef ALU_ARB_FLAGREG_EN
    logic              set_flags0;
    logic              set_flags1;
    logic [3:0]        flags0_q;
    logic [3:0]        flags1_q;
`endif

    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1,
`ifdef ALU_ARB_FLAGREG_EN
        output set_flags0, set_flags1,
        input  flags0_q, flags1_q,
`endif
        input  gnt0, gnt1, rsp_valid0, rsp_valid1, result, flags, busy
    );

    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1,
`ifdef ALU_ARB_FLAGREG_EN
        input  set_flags0, set_flags1,
        output flags0_q, flags1_q,
`endif
        output gnt0, gnt1, rsp_valid0, rsp_valid1, result, flags, busy
    );
endinterface

// File: rtl/alu_share_arb_alu.sv
// Fixed 32-bit single-cycle ALU with NZCV flags. SUB carry is NOT borrow;
// undefined op codes give result 0 and therefore flags 0100.
module alu
    import alu_share_arb_pkg::*;
(
    input  logic [2:0]       op,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] result,
    output logic [3:0]       flags
);
    logic             is_sub;
    logic [ALU_W-1:0] b_eff;
    logic [ALU_W:0]   sum;
    logic             carry;
    logic             ovf;

    // SUB is a + ~b + 1, so one adder serves both and carry-out is NOT borrow.
    assign is_sub = (op == ALU_SUB);
    assign b_eff  = is_sub ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_eff} + {{ALU_W{1'b0}}, is_sub};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                result = sum[ALU_W-1:0];
                carry  = sum[ALU_W];
                ovf    = (a[ALU_W-1] == b_eff[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
            end
            ALU_AND: result = a & b;
            ALU_ORR: result = a | b;
            ALU_EOR: result = a ^ b;
            default: result = '0;
        endcase
    end

    always_comb begin
        flags         = FLAGS_RESET;
        flags[FLAG_N] = result[ALU_W-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end
endmodule

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin picker. Owns the last-granted pointer; grants are
// combinational and forced low while reset is high.
module rr_arb2 #(
    parameter logic RR_INIT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last_reg;
    logic last_next;

    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            gnt[0] = req[0] & (~req[1] |  last_reg);
            gnt[1] = req[1] & (~req[0] | ~last_reg);
        end
        last_next = (|gnt) ? gnt[1] : last_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg <= RR_INIT;
        end else begin
            last_reg <= last_next;
        end
    end
endmodule

// File: rtl/alu_share_arb.sv
// Shares one 32-bit ALU between two requesters with round-robin grant and a
// one-cycle registered, tagged response. Option: ALU_ARB_FLAGREG_EN adds per-requester NZCV registers.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RR_INIT = 1
) (
    input  logic           clk,
    input  logic           reset,
    alu_share_arb_if.slave bus
);
    logic [1:0]        req_vec;
    logic [1:0]        gnt_vec;
    alu_req_t          sel_req;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;
    logic [1:0]        rsp_valid_reg;
    logic [DATA_W-1:0] result_reg;
    logic [3:0]        flags_reg;

    assign req_vec = {bus.req1, bus.req0};

    rr_arb2 #(.RR_INIT(RR_INIT != 0)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_vec),
        .gnt   (gnt_vec)
    );

    assign bus.gnt0 = gnt_vec[0];
    assign bus.gnt1 = gnt_vec[1];

    // Grants are one-hot, so gnt1 alone picks the operand set.
    assign sel_req = gnt_vec[1] ? {bus.op1, bus.a1, bus.b1} : {bus.op0, bus.a0, bus.b0};

    alu u_alu (
        .op     (sel_req.op),
        .a      (sel_req.a),
        .b      (sel_req.b),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_reg <= 2'b00;
            result_reg    <= '0;
            flags_reg     <= FLAGS_RESET;
        end else begin
            rsp_valid_reg <= gnt_vec;
            if (|gnt_vec) begin
                result_reg <= alu_result;
                flags_reg  <= alu_flags;
            end
        end
    end

    assign bus.rsp_valid0 = rsp_valid_reg[0];
    assign bus.rsp_valid1 = rsp_valid_reg[1];
    assign bus.result     = result_reg;
    assign bus.flags      = flags_reg;
    assign bus.busy       = |rsp_valid_reg;

`ifdef ALU_ARB_FLAGREG_EN
    logic [1:0] set_flags_vec;
    logic [3:0] flags_q_arr [2];

    assign set_flags_vec = {bus.set_flags1, bus.set_flags0};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_flagreg
            logic [3:0] flags_q_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    flags_q_reg <= FLAGS_RESET;
                end else if (gnt_vec[gi] && set_flags_vec[gi]) begin
                    flags_q_reg <= alu_flags;
                end
            end
            assign flags_q_arr[gi] = flags_q_reg;
        end
    endgenerate

    assign bus.flags0_q = flags_q_arr[0];
    assign bus.flags1_q = flags_q_arr[1];
`endif
endmodule
